// File: rtl/bk_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : bk_seq_pkg                                                   |
// | Description : Shared types and helpers for the multi-word add sequencer.   |
// |               W_ADD      - width of the shared adder word                  |
// |               state_e    - sequencer FSM states                            |
// |               interleave - packs two W_ADD words into the adder's          |
// |                            bit-interleaved input vector                    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package bk_seq_pkg;

  localparam int W_ADD = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    INC  = 2'd2,
    RESP = 2'd3
  } state_e;

  // The adder expects a and b bits interleaved: bit 2i = a[i], bit 2i+1 = b[i].
  function automatic logic [2*W_ADD-1:0] interleave(input logic [W_ADD-1:0] a,
                                                    input logic [W_ADD-1:0] b);
    logic [2*W_ADD-1:0] v;
    v = '0;
    for (int i = 0; i < W_ADD; i++) begin
      v[2*i]   = a[i];
      v[2*i+1] = b[i];
    end
    return v;
  endfunction

endpackage : bk_seq_pkg
`default_nettype wire

// File: rtl/bk_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bk_rr_arbiter                                                |
// | Description : Combinational round-robin pick. Grants the first asserted    |
// |               request at or after ptr_i, wrapping modulo NREQ.             |
// | Ports       : req_i       in  NREQ   request vector                        |
// |               ptr_i       in  IW     highest-priority index                |
// |               gnt_valid_o out 1      some request is granted               |
// |               gnt_idx_o   out IW     index of the granted request          |
// |               gnt_oh_o    out NREQ   one-hot grant                         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module bk_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic            gnt_valid_o,
  output logic [IW-1:0]   gnt_idx_o,
  output logic [NREQ-1:0] gnt_oh_o
);

  // (base + off) mod NREQ, valid because base < NREQ and off < NREQ.
  function automatic logic [IW-1:0] f_wrap(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s[IW-1:0];
  endfunction

  // Scan from the lowest priority to the highest so the last hit wins.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    gnt_oh_o    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[f_wrap(ptr_i, i)]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = f_wrap(ptr_i, i);
      end
    end
    if (gnt_valid_o) gnt_oh_o[gnt_idx_o] = 1'b1;
  end

endmodule : bk_rr_arbiter
`default_nettype wire

// File: rtl/bk_add_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bk_add_sequencer                                             |
// | Description : Multi-word add sequencer and round-robin arbiter in front of |
// |               one shared external W-bit adder (no carry-in). Each request  |
// |               computes A+B+cin over WORDS words, one word per adder pass;  |
// |               a pending carry costs one extra increment pass.              |
// | Ports       : clk, rst                synchronous active-high reset        |
// |               req_valid_i/req_ready_o per-requester valid / accept pulse   |
// |               req_a_i, req_b_i        operands, requester r at             |
// |                                       [r*WORDS*W +: WORDS*W]               |
// |               req_cin_i               carry-in per requester               |
// |               rsp_valid_o/rsp_ready_i result handshake                     |
// |               rsp_id_o, rsp_sum_o, rsp_cout_o   result fields              |
// |               add_in_o                interleaved adder inputs             |
// |               add_out_i               adder {cout, sum}                    |
// | Option      : BKSEQ_PERF_CNT_EN adds perf_ops_o (completed responses)      |
// |               and perf_inc_o (increment passes), both 32-bit wrapping.     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module bk_add_sequencer
  import bk_seq_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WORDS = 4,
  parameter int W     = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid_i,
  output logic [NREQ-1:0]         req_ready_o,
  input  logic [NREQ*WORDS*W-1:0] req_a_i,
  input  logic [NREQ*WORDS*W-1:0] req_b_i,
  input  logic [NREQ-1:0]         req_cin_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [$clog2(NREQ)-1:0] rsp_id_o,
  output logic [WORDS*W-1:0]      rsp_sum_o,
  output logic                    rsp_cout_o,
  output logic [2*W-1:0]          add_in_o,
  input  logic [W:0]              add_out_i
`ifdef BKSEQ_PERF_CNT_EN
  ,
  output logic [31:0]             perf_ops_o,
  output logic [31:0]             perf_inc_o
`endif
);

  localparam int IW = $clog2(NREQ);
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int OW = WORDS * W;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic            carry_q, carry_d;
  logic            c1_q, c1_d;
  logic [OW-1:0]   a_q, a_d;
  logic [OW-1:0]   b_q, b_d;
  logic [OW-1:0]   s_q, s_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IW-1:0]   rsp_id_q, rsp_id_d;
  logic            rsp_cout_q, rsp_cout_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;

  logic            w_gnt_valid;
  logic [IW-1:0]   w_gnt_idx;
  logic [NREQ-1:0] w_gnt_oh;
  logic            w_accept;
  logic            w_last;
  logic            w_carry_new;

  bk_rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req_i       (req_valid_i),
    .ptr_i       (rr_ptr_q),
    .gnt_valid_o (w_gnt_valid),
    .gnt_idx_o   (w_gnt_idx),
    .gnt_oh_o    (w_gnt_oh)
  );

  // Grant only from IDLE with no result pending; rst masks the pulse so the
  // port reads 0 while reset is held.
  assign w_accept    = (state_q == IDLE) && w_gnt_valid && !rsp_valid_q && !rst;
  assign req_ready_o = w_accept ? w_gnt_oh : '0;
  assign w_last      = (k_q == KW'(WORDS - 1));

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    carry_d     = carry_q;
    c1_d        = c1_q;
    a_d         = a_q;
    b_d         = b_q;
    s_d         = s_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_cout_d  = rsp_cout_q;
    rr_ptr_d    = rr_ptr_q;
    add_in_o    = '0;
    w_carry_new = carry_q;

    unique case (state_q)
      IDLE: begin
        if (w_accept) begin
          a_d      = req_a_i[w_gnt_idx*OW +: OW];
          b_d      = req_b_i[w_gnt_idx*OW +: OW];
          carry_d  = req_cin_i[w_gnt_idx];
          k_d      = '0;
          rsp_id_d = w_gnt_idx;
          rr_ptr_d = (w_gnt_idx == IW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
          state_d  = ADD;
        end
      end

      ADD: begin
        add_in_o           = interleave(a_q[k_q*W +: W], b_q[k_q*W +: W]);
        s_d[k_q*W +: W]    = add_out_i[W-1:0];
        if (carry_q) begin
          // Pending carry: park this pass's carry and add the 1 next cycle.
          c1_d    = add_out_i[W];
          state_d = INC;
        end else begin
          w_carry_new = add_out_i[W];
          carry_d     = w_carry_new;
          if (w_last) begin
            rsp_cout_d  = w_carry_new;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end

      INC: begin
        add_in_o        = interleave(s_q[k_q*W +: W], W'(1));
        s_d[k_q*W +: W] = add_out_i[W-1:0];
        // Incrementing can only carry out if the word was all ones, which
        // the preceding add cannot produce together with its own carry.
        w_carry_new = c1_q | add_out_i[W];
        carry_d     = w_carry_new;
        if (w_last) begin
          rsp_cout_d  = w_carry_new;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = ADD;
        end
      end

      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      carry_q     <= 1'b0;
      c1_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_cout_q  <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      carry_q     <= carry_d;
      c1_q        <= c1_d;
      a_q         <= a_d;
      b_q         <= b_d;
      s_q         <= s_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_cout_q  <= rsp_cout_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_sum_o   = s_q;
  assign rsp_cout_o  = rsp_cout_q;

`ifdef BKSEQ_PERF_CNT_EN
  logic [31:0] perf_ops_q;
  logic [31:0] perf_inc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops_q <= '0;
      perf_inc_q <= '0;
    end else begin
      if (rsp_valid_q && rsp_ready_i) perf_ops_q <= perf_ops_q + 32'd1;
      if (state_q == INC)             perf_inc_q <= perf_inc_q + 32'd1;
    end
  end

  assign perf_ops_o = perf_ops_q;
  assign perf_inc_o = perf_inc_q;
`endif

endmodule : bk_add_sequencer
`default_nettype wire

// File: tb/tb_bk_add_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bk_add_sequencer                                          |
// | Description : Self-checking bench for bk_add_sequencer with a behavioural  |
// |               12-bit adder on the add_in/add_out port pair. Directed       |
// |               vector table, hand-written corner sequences and random ops   |
// |               against an arithmetic reference model. Perf counters are     |
// |               checked when BKSEQ_PERF_CNT_EN is defined.                   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_bk_add_sequencer;

  localparam int NREQ  = 2;
  localparam int WORDS = 4;
  localparam int W     = 12;
  localparam int OW    = WORDS * W;

  logic                    clk;
  logic                    rst;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*OW-1:0]      req_a;
  logic [NREQ*OW-1:0]      req_b;
  logic [NREQ-1:0]         req_cin;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [0:0]              rsp_id;
  logic [OW-1:0]           rsp_sum;
  logic                    rsp_cout;
  logic [2*W-1:0]          add_in;
  logic [W:0]              add_out;
`ifdef BKSEQ_PERF_CNT_EN
  logic [31:0]             perf_ops;
  logic [31:0]             perf_inc;
`endif

  bk_add_sequencer #(
    .NREQ  (NREQ),
    .WORDS (WORDS),
    .W     (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_cin_i   (req_cin),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_sum_o   (rsp_sum),
    .rsp_cout_o  (rsp_cout),
    .add_in_o    (add_in),
    .add_out_i   (add_out)
`ifdef BKSEQ_PERF_CNT_EN
    ,
    .perf_ops_o  (perf_ops),
    .perf_inc_o  (perf_inc)
`endif
  );

  // Behavioural shared adder: de-interleave and add, no carry-in.
  logic [W-1:0] ad_a, ad_b;
  always_comb begin
    ad_a = '0;
    ad_b = '0;
    for (int i = 0; i < W; i++) begin
      ad_a[i] = add_in[2*i];
      ad_b[i] = add_in[2*i+1];
    end
  end
  assign add_out = {1'b0, ad_a} + {1'b0, ad_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_err = 0;
  int n_chk = 0;
  int exp_ops = 0;
  int exp_inc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference: whole-operand arithmetic; one increment pass per word whose
  // incoming carry (from the lower words plus cin) is 1.
  function automatic void model(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic cin,
                                output logic [OW-1:0] s, output logic co, output int incs);
    logic [OW:0] full;
    logic [OW:0] mask;
    logic [OW:0] part;
    full = {1'b0, a} + {1'b0, b} + (OW+1)'(cin);
    s    = full[OW-1:0];
    co   = full[OW];
    incs = 0;
    for (int k = 0; k < WORDS; k++) begin
      mask = ((OW+1)'(1) << (W*k)) - 1'b1;
      part = ({1'b0, a} & mask) + ({1'b0, b} & mask) + (OW+1)'(cin);
      incs += int'(part[W*k]);
    end
  endfunction

  // One complete transaction on requester r; elat counts cycles from the
  // accept cycle to the first cycle rsp_valid is seen.
  task automatic do_op(input int r, input logic [OW-1:0] a, input logic [OW-1:0] b, input logic cin,
                       input logic [OW-1:0] es, input logic ec, input int elat);
    int t0;
    int n;
    logic [NREQ-1:0] oh;
    req_a[r*OW +: OW] = a;
    req_b[r*OW +: OW] = b;
    req_cin[r]        = cin;
    req_valid[r]      = 1'b1;
    #1;
    n = 0;
    while (req_ready[r] !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    oh = '0;
    oh[r] = 1'b1;
    check("grant", req_ready, oh);
    t0 = cyc;
    step();
    // Operands only need to be held during the accept cycle.
    req_valid[r]      = 1'b0;
    req_a[r*OW +: OW] = ~a;
    req_b[r*OW +: OW] = ~b;
    req_cin[r]        = ~cin;
    #1;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("rsp_valid", rsp_valid, 1);
    check("latency", cyc - t0, elat);
    check("rsp_sum", rsp_sum, es);
    check("rsp_cout", rsp_cout, ec);
    check("rsp_id", rsp_id, r);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    exp_ops++;
    exp_inc += elat - 1 - WORDS;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_id"}, rsp_id, 0);
    check({tag, "_rsp_sum"}, rsp_sum, 0);
    check({tag, "_rsp_cout"}, rsp_cout, 0);
    check({tag, "_add_in"}, add_in, 0);
`ifdef BKSEQ_PERF_CNT_EN
    check({tag, "_perf_ops"}, perf_ops, 0);
    check({tag, "_perf_inc"}, perf_inc, 0);
`endif
  endtask

  typedef struct {
    int          r;
    logic [47:0] a;
    logic [47:0] b;
    logic        cin;
    logic [47:0] sum;
    logic        cout;
    int          lat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [63:0] ta, tb;
    logic [OW-1:0] ra, rb, es;
    logic rc, ec;
    int rr, ei, grants, hs, n;
    logic [OW-1:0] hold_sum;
    logic hold_cout;
    logic [0:0] hold_id;

    vecs[0] = '{0, 48'hFFFFFFFFFFFF, 48'h000000000001, 1'b0, 48'h000000000000, 1'b1, 8};
    vecs[1] = '{1, 48'h000000000000, 48'h000000000000, 1'b1, 48'h000000000001, 1'b0, 6};
    vecs[2] = '{0, 48'h123456789ABC, 48'h111111111111, 1'b0, 48'h23456789ABCD, 1'b0, 5};
    vecs[3] = '{1, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 1'b1, 48'hFFFFFFFFFFFF, 1'b1, 9};
    vecs[4] = '{0, 48'h000000000FFF, 48'h000000000000, 1'b1, 48'h000000001000, 1'b0, 7};
    vecs[5] = '{1, 48'h800800800800, 48'h800800800800, 1'b0, 48'h001001001000, 1'b1, 8};

    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    rsp_ready = 1'b0;

    // Reset state, with requests raised to show req_ready stays low.
    step();
    req_valid = 2'b11;
    step();
    check_reset_outputs("reset");
    req_valid = '0;
    rst = 1'b0;
    step();

    // Directed vectors.
    for (int i = 0; i < 6; i++)
      do_op(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].lat);

    // Both requesters held valid: grants alternate 0,1,0,1 after each handshake.
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_ops = 0;
    exp_inc = 0;
    req_a[0 +: OW]  = 48'd1;
    req_b[0 +: OW]  = 48'd2;
    req_cin[0]      = 1'b0;
    req_a[OW +: OW] = 48'd5;
    req_b[OW +: OW] = 48'd6;
    req_cin[1]      = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    grants = 0;
    hs = 0;
    #1;
    for (int c = 0; c < 200 && hs < 4; c++) begin
      if (req_ready != 0) begin
        check("rr_grant", req_ready, (grants % 2 == 0) ? 2'b01 : 2'b10);
        check("rr_grant_after_rsp", grants, hs);
        grants++;
      end
      if (rsp_valid && rsp_ready) begin
        check("rr_rsp_id", rsp_id, hs % 2);
        check("rr_rsp_sum", rsp_sum, (hs % 2 == 0) ? 48'd3 : 48'd12);
        exp_ops++;
        exp_inc += hs % 2;
        hs++;
      end
      if (hs < 4) step();
    end
    req_valid = '0;
    check("rr_handshakes", hs, 4);
    step();
    rsp_ready = 1'b0;

    // Backpressure: rsp held 5 cycles, accepted on the 6th; no grant meanwhile.
    req_a[0 +: OW] = 48'h000000000FFF;
    req_b[0 +: OW] = 48'h000000000001;
    req_cin[0]     = 1'b0;
    req_valid[0]   = 1'b1;
    #1;
    n = 0;
    while (req_ready[0] !== 1'b1 && n < 40) begin step(); n++; end
    check("bp_grant", req_ready, 2'b01);
    step();
    req_valid[0]    = 1'b0;
    req_a[OW +: OW] = 48'h1;
    req_valid[1]    = 1'b1;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin step(); n++; end
    check("bp_sum", rsp_sum, 48'h000000001000);
    check("bp_cout", rsp_cout, 0);
    check("bp_id", rsp_id, 0);
    hold_sum  = rsp_sum;
    hold_cout = rsp_cout;
    hold_id   = rsp_id;
    for (int i = 1; i < 5; i++) begin
      step();
      check("bp_valid_held", rsp_valid, 1);
      check("bp_sum_stable", rsp_sum, hold_sum);
      check("bp_cout_stable", rsp_cout, hold_cout);
      check("bp_id_stable", rsp_id, hold_id);
      check("bp_no_grant", req_ready, 0);
    end
    step();
    check("bp_valid_cycle6", rsp_valid, 1);
    rsp_ready    = 1'b1;
    req_valid[1] = 1'b0;
    step();
    rsp_ready = 1'b0;
    check("bp_released", rsp_valid, 0);
    exp_ops++;
    exp_inc += 1;

    // Reset during the increment pass of word 2.
    req_a[0 +: OW] = 48'hFFFFFFFFFFFF;
    req_b[0 +: OW] = 48'h000000000001;
    req_cin[0]     = 1'b0;
    req_valid[0]   = 1'b1;
    #1;
    n = 0;
    while (req_ready[0] !== 1'b1 && n < 40) begin step(); n++; end
    check("mid_grant", req_ready, 2'b01);
    step();
    req_valid[0] = 1'b0;
    repeat (4) step();
    check("mid_inc_a", ad_a, 12'hFFF);
    check("mid_inc_b", ad_b, 12'h001);
    rst = 1'b1;
    req_valid = 2'b11;
    step();
    check_reset_outputs("mid_reset");
    rst = 1'b0;
    exp_ops = 0;
    exp_inc = 0;
    #1;
    check("mid_ptr_reset", req_ready, 2'b01);
    req_valid = '0;
    step();
    do_op(0, 48'h000000000ABC, 48'h000000000001, 1'b0, 48'h000000000ABD, 1'b0, 5);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 1000; i++) begin
      ta = {$urandom(), $urandom()};
      tb = {$urandom(), $urandom()};
      ra = ta[OW-1:0];
      rb = ($urandom_range(0, 3) == 0) ? ~ra : tb[OW-1:0];
      rc = 1'($urandom_range(0, 1));
      rr = int'($urandom_range(0, NREQ - 1));
      model(ra, rb, rc, es, ec, ei);
      do_op(rr, ra, rb, rc, es, ec, 1 + WORDS + ei);
    end

`ifdef BKSEQ_PERF_CNT_EN
    check("perf_ops", perf_ops, exp_ops);
    check("perf_inc", perf_inc, exp_inc);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_bk_add_sequencer
`default_nettype wire
